// File: rtl/mac4_stream.sv
// Streaming 4x4 multiply-accumulate: a 2-stage valid/ready pipeline that sums
// TERMS consecutive unsigned products into one ACC_W-bit result with an overflow flag.

module mul4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p + (8'(a) << i);
        end
    end
endmodule

module mac4_stream #(
    parameter int ACC_W = 16,
    parameter int TERMS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;

    typedef struct packed {
        logic       vld;
        logic [3:0] a;
        logic [3:0] b;
    } s1_t;

    typedef struct packed {
        logic             vld;
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } res_t;

    s1_t              s1_q, s1_d;
    res_t             res_q, res_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]       p;
    logic [ACC_W:0]   sum_full;
    logic             final_t, s2_go, load;

    mul4 u_mul (.a(s1_q.a), .b(s1_q.b), .p(p));

    always_comb begin
        sum_full = {1'b0, acc_q} + (ACC_W+1)'(p);
        final_t  = s1_q.vld && (cnt_q == CNT_W'(TERMS - 1));
        // A final term only moves when the output slot is free or being retired.
        s2_go    = s1_q.vld && (!final_t || !res_q.vld || out_ready);
        in_ready = !s1_q.vld || s2_go;
        load     = s2_go && final_t && !clear;

        s1_d      = s1_q;
        res_d     = res_q;
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        cnt_d     = cnt_q;

        if (in_valid && in_ready) begin
            s1_d.vld = 1'b1;
            s1_d.a   = in_a;
            s1_d.b   = in_b;
        end else if (s2_go) begin
            s1_d.vld = 1'b0;
        end

        if (s2_go && !final_t) begin
            acc_d     = sum_full[ACC_W-1:0];
            acc_ovf_d = acc_ovf_q | sum_full[ACC_W];
            cnt_d     = cnt_q + CNT_W'(1);
        end else if (s2_go && final_t) begin
            acc_d     = '0;
            acc_ovf_d = 1'b0;
            cnt_d     = '0;
        end

        if (load) begin
            res_d.vld = 1'b1;
            res_d.sum = sum_full[ACC_W-1:0];
            res_d.ovf = acc_ovf_q | sum_full[ACC_W];
        end else if (res_q.vld && out_ready) begin
            res_d.vld = 1'b0;
        end

        // Flush drops the partial set and whatever sits in or enters stage 1,
        // but leaves a completed result untouched.
        if (clear) begin
            s1_d.vld  = 1'b0;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q      <= '0;
            res_q     <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            res_q     <= res_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid = res_q.vld;
    assign out_sum   = res_q.sum;
    assign out_ovf   = res_q.ovf;
endmodule

// File: tb/tb_mac4_stream.sv
// Directed bench for mac4_stream: a 16-bit and an 8-bit accumulator instance
// share one stimulus stream; expected values are hand-computed constants.

module tb_mac4_stream;
    logic        clk = 1'b0;
    logic        reset_n, clear, in_valid, out_ready;
    logic [3:0]  in_a, in_b;
    logic        rdy16, rdy8, vld16, vld8, ovf16, ovf8;
    logic [15:0] sum16;
    logic [7:0]  sum8;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mac4_stream #(.ACC_W(16), .TERMS(4)) u16 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(rdy16), .in_a(in_a), .in_b(in_b), .out_valid(vld16),
        .out_ready(out_ready), .out_sum(sum16), .out_ovf(ovf16));

    mac4_stream #(.ACC_W(8), .TERMS(4)) u8 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(rdy8), .in_a(in_a), .in_b(in_b), .out_valid(vld8),
        .out_ready(out_ready), .out_sum(sum8), .out_ovf(ovf8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair and hold it until the 16-bit instance accepts it (bounded).
    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int   n = 0;
        logic r;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        do begin
            #1 r = rdy16;
            tick();
            n++;
        end while (!r && n < 20);
        in_valid = 1'b0;
        if (!r) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=0 expected=1");
        end
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;

        // Reset
        tick(); tick();
        chk("rst_vld", vld16, 0);
        chk("rst_sum", sum16, 0);
        chk("rst_ovf", ovf16, 0);
        chk("rst_vld8", vld8, 0);
        reset_n = 1'b1;
        #1 chk("rst_ready", rdy16, 1);

        // Basic dot product: 15+225+0+14
        send(3, 5); send(15, 15); send(0, 9); send(7, 2);
        chk("dp_early_vld", vld16, 0);
        tick();
        chk("dp_vld", vld16, 1);
        chk("dp_sum", sum16, 254);
        chk("dp_ovf", ovf16, 0);
        tick();
        chk("dp_retired", vld16, 0);

        // Backpressure: result 4 held, second final stalls, then both drain in order
        out_ready = 1'b0;
        send(1, 1); send(1, 1); send(1, 1); send(1, 1);
        send(2, 2); send(2, 2); send(2, 2); send(2, 2);
        chk("bp_vld", vld16, 1);
        chk("bp_sum_held", sum16, 4);
        #1 chk("bp_ready_low", rdy16, 0);
        tick();
        chk("bp_sum_stable", sum16, 4);
        #1 chk("bp_ready_still_low", rdy16, 0);
        out_ready = 1'b1;
        #1 chk("bp_ready_release", rdy16, 1);
        tick();
        chk("bp_b2b_vld", vld16, 1);
        chk("bp_b2b_sum", sum16, 16);
        tick();
        chk("bp_drained", vld16, 0);

        // Overflow on the narrow instance: 900 mod 256 = 132
        send(15, 15); send(15, 15); send(15, 15); send(15, 15);
        tick();
        chk("ovf8_vld", vld8, 1);
        chk("ovf8_sum", sum8, 132);
        chk("ovf8_flag", ovf8, 1);
        chk("ovf16_sum", sum16, 900);
        chk("ovf16_flag", ovf16, 0);
        send(1, 1); send(1, 1); send(1, 1); send(1, 1);
        tick();
        chk("ovf8_next_sum", sum8, 4);
        chk("ovf8_next_flag", ovf8, 0);
        tick();

        // Clear: pending result 36 survives, partial (9,9)x2 and offered (8,8) dropped
        out_ready = 1'b0;
        send(3, 3); send(3, 3); send(3, 3); send(3, 3);
        send(9, 9); send(9, 9);
        clear = 1'b1; in_valid = 1'b1; in_a = 8; in_b = 8;
        #1 chk("clr_ready_unaffected", rdy16, 1);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_pending_vld", vld16, 1);
        chk("clr_pending_sum", sum16, 36);
        #1 chk("clr_ready_after", rdy16, 1);
        out_ready = 1'b1;
        tick();
        chk("clr_retired", vld16, 0);
        send(1, 1); send(1, 1); send(1, 1); send(1, 1);
        tick();
        chk("clr_new_vld", vld16, 1);
        chk("clr_new_sum", sum16, 4);
        chk("clr_new_ovf", ovf16, 0);
        tick();

        // Reset mid-set with a pending result
        out_ready = 1'b0;
        send(2, 3); send(2, 3); send(2, 3); send(2, 3);
        send(1, 1); send(1, 1); send(1, 1);
        chk("mid_pending_vld", vld16, 1);
        chk("mid_pending_sum", sum16, 24);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_vld", vld16, 0);
        chk("mid_rst_sum", sum16, 0);
        chk("mid_rst_ovf", ovf16, 0);
        chk("mid_rst_sum8", sum8, 0);
        #1 chk("mid_rst_ready", rdy16, 1);
        out_ready = 1'b1;
        send(1, 2); send(1, 2); send(1, 2); send(1, 2);
        tick();
        chk("mid_clean_vld", vld16, 1);
        chk("mid_clean_sum", sum16, 8);
        chk("mid_clean_sum8", sum8, 8);
        chk("mid_clean_ovf", ovf16, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
